udc_config_sequencer: RTL
=========================

Name: udc_config_sequencer

Overview:
Bus-master stage that sits directly upstream of the 8-bit up/down counter. It accepts one configuration request (PLR/ULR/LLR/CCR), range-checks it, and writes the four registers over the counter's chip-select/read/write bus. It optionally reads them back, fires the start pulse, then supervises the run until end-of-cycle or timeout. It reports done/fail with a code to the host.

Parameters:
START_W, 2, start_out high width in clk_in cycles (1..15)
TIMEOUT, 16'd65535, max cycles in RUN waiting for ec_in before failing
RD_WAIT, 2, cycles nrd_out held low per readback (data sampled at last cycle)

Ports:
clk_in  input  1  system clock, all logic on posedge
reset_in  input  1  synchronous, active-high reset
req_in  input  1  host request; sampled only in IDLE
plr_in  input  8  preload value
ulr_in  input  8  upper limit
llr_in  input  8  lower limit
ccr_in  input  8  cycle count
ec_in  input  1  counter end-cycle flag
err_in  input  1  counter error flag
din_io  inout  8  counter data bus; driven only while nwr_out=0, else 8'bz
ncs_out  output  1  counter chip select, active-low
nrd_out  output  1  counter read strobe, active-low
nwr_out  output  1  counter write strobe, active-low
a1_out, a0_out  output  1 each  register address (00 PLR, 01 ULR, 10 LLR, 11 CCR)
start_out  output  1  counter start pulse
busy_out  output  1  high in any state except IDLE
done_out  output  1  one-cycle pulse on successful end-cycle
fail_out  output  1  one-cycle pulse on failure
fail_code_out  output  2  00 none, 01 range, 10 readback mismatch, 11 timeout/err; held until next req accepted

Behaviour:
- Reset values: ncs_out=1, nrd_out=1, nwr_out=1, address=00, start_out=0, busy/done/fail=0, fail_code=00, din_io=z, FSM=IDLE, all counters 0. Reset mid-operation aborts immediately and releases the bus next edge.
- Request capture: in IDLE with req_in=1, latch all four inputs. Go to CHECK and clear fail_code. req_in outside IDLE is ignored.
- CHECK (1 cycle): if LLR<=PLR<=ULR and CCR!=0, go to WR. Otherwise fail with code 01. Compares are unsigned 8-bit.
- WR: ncs_out=0 for the whole transaction. Four writes in order 00,01,10,11. Each write takes 1 cycle with nwr_out=0 and din_io=value, followed by 1 idle cycle with nwr_out=1 and the bus at z. Total 8 cycles.
- RD: only with the optional feature enabled. Per address, hold nrd_out=0 for RD_WAIT cycles and sample din_io on the last one, then spend 1 cycle with nrd_out=1. Any mismatch fails with code 10 after the current read completes.
- START: nwr_out=1, nrd_out=1, start_out=1 for START_W cycles, then 0. Enter RUN on the falling edge of start_out.
- RUN: ncs_out stays 0. A 16-bit timer counts up. ec_in=1 gives DONE, pulsing done_out for 1 cycle. err_in=1 or timer==TIMEOUT fails with code 11. If ec_in and err_in are high in the same cycle, ec_in wins.
- DONE/FAIL: 1-cycle pulse, then IDLE with ncs_out=1 and busy_out=0.
- nrd_out and nwr_out are never low simultaneously. The bus is never driven while nrd_out=0.

Optional Feature:
READBACK_EN
- Defined: the RD state is compiled in, inserted between WR and START, with mismatch detection (code 10).
- Undefined: WR goes directly to START, and fail code 10 is never produced.

Test Plan:
- PLR=20, ULR=30, LLR=10, CCR=2, counter model returns ec after 40 cycles -> writes 20/30/10/2 to addresses 00..11 in order, start_out high 2 cycles, done_out pulse, fail_code=00.
- PLR=5, LLR=10 -> fail_out pulse 2 cycles after req_in, fail_code=01, nwr_out never low.
- READBACK_EN defined, model corrupts ULR readback to 31 -> fail_code=10, start_out never asserted.
- ec_in never asserted, TIMEOUT=100 -> fail_out exactly 100 cycles after RUN entry, code 11, ncs_out returns to 1.
- reset_in=1 during the third write -> next cycle ncs_out=1, nwr_out=1, din_io=z, busy_out=0. A new req_in then completes normally.
- req_in pulsed during RUN -> ignored; latched values unchanged, single done_out.

Source files
------------

// File: rtl/udc_config_sequencer_if.sv
// ---------------------------------------------------------------------------
// udc_config_sequencer_if
//
// Host-side handshake bundle for the up/down counter configuration sequencer.
// The host raises req_in together with the four register values and then
// watches busy/done/fail and the fail code.
//
// Signals:
//   req_in         host request (sampled by the sequencer only while idle)
//   plr_in         preload value
//   ulr_in         upper limit
//   llr_in         lower limit
//   ccr_in         cycle count
//   busy_out       sequencer is working on a request
//   done_out       one-cycle pulse on successful end-cycle
//   fail_out       one-cycle pulse on failure
//   fail_code_out  00 none, 01 range, 10 readback mismatch, 11 timeout/err
//
// Modports:
//   master  the host that issues requests
//   slave   the sequencer that serves them
// ---------------------------------------------------------------------------
interface udc_config_sequencer_if;
  logic       req_in;
  logic [7:0] plr_in;
  logic [7:0] ulr_in;
  logic [7:0] llr_in;
  logic [7:0] ccr_in;
  logic       busy_out;
  logic       done_out;
  logic       fail_out;
  logic [1:0] fail_code_out;

  modport master (
    output req_in, plr_in, ulr_in, llr_in, ccr_in,
    input  busy_out, done_out, fail_out, fail_code_out
  );

  modport slave (
    input  req_in, plr_in, ulr_in, llr_in, ccr_in,
    output busy_out, done_out, fail_out, fail_code_out
  );
endinterface

// File: rtl/udc_config_sequencer.sv
// ---------------------------------------------------------------------------
// udc_config_sequencer
//
// Bus master sitting directly upstream of the 8-bit up/down counter. It takes
// one configuration request (PLR/ULR/LLR/CCR) from the host, range-checks it,
// writes the four counter registers over the chip-select/read/write bus,
// optionally reads them back, fires the start pulse and then supervises the
// run until end-of-cycle, error or timeout.
//
// Optional feature macro: READBACK_EN
//   defined   : a readback pass (RD) runs between the writes and the start
//               pulse; any mismatch ends the request with fail code 10.
//   undefined : the writes go straight to the start pulse and code 10 is
//               never produced.
//
// Parameters:
//   START_W  start_out high width in clk_in cycles (1..15)
//   TIMEOUT  max cycles spent in RUN waiting for ec_in before failing
//   RD_WAIT  cycles nrd_out is held low per readback (sampled on the last)
//
// Ports:
//   clk_in     system clock, all logic on posedge
//   reset_in   synchronous active-high reset
//   host       host handshake bundle (slave side)
//   ec_in      counter end-cycle flag
//   err_in     counter error flag
//   din_io     counter data bus, driven only while nwr_out=0
//   ncs_out    counter chip select, active-low
//   nrd_out    counter read strobe, active-low
//   nwr_out    counter write strobe, active-low
//   a1_out     register address bit 1 (00 PLR, 01 ULR, 10 LLR, 11 CCR)
//   a0_out     register address bit 0
//   start_out  counter start pulse
// ---------------------------------------------------------------------------
module udc_config_sequencer #(
  parameter int          START_W = 2,
  parameter logic [15:0] TIMEOUT = 16'd65535,
  parameter int          RD_WAIT = 2
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  udc_config_sequencer_if.slave         host,
  input  logic                          ec_in,
  input  logic                          err_in,
  inout  wire  [7:0]                    din_io,
  output logic                          ncs_out,
  output logic                          nrd_out,
  output logic                          nwr_out,
  output logic                          a1_out,
  output logic                          a0_out,
  output logic                          start_out
);

  // One small counter is shared between the start-pulse width and the
  // readback strobe timing, so it is sized for whichever needs more.
  localparam int CNT_MAX = (START_W > RD_WAIT) ? START_W : RD_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_W - 1);
`ifdef READBACK_EN
  localparam logic [CNT_W-1:0] RD_SAMPLE  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_WAIT);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WR,
    S_RD,
    S_START,
    S_RUN,
    S_DONE,
    S_FAIL
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [7:0]        r_plr;
  logic [7:0]        r_ulr;
  logic [7:0]        r_llr;
  logic [7:0]        r_ccr;
  logic [2:0]        r_step;
  logic [2:0]        w_stepNext;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cntNext;
  logic [15:0]       r_timer;
  logic [15:0]       w_timerNext;
  logic [15:0]       w_timerInc;
  logic [1:0]        r_failCode;
  logic [1:0]        w_failCodeNext;
  logic              w_latch;
  logic [1:0]        w_addr;
  logic              w_busOe;
  logic [7:0]        w_busData;
`ifdef READBACK_EN
  logic              r_mismatch;
  logic              w_mismatchNext;
`endif

  // Register value that belongs at a given counter address.
  function automatic logic [7:0] regSel(input logic [1:0] addr);
    case (addr)
      2'd0:    regSel = r_plr;
      2'd1:    regSel = r_ulr;
      2'd2:    regSel = r_llr;
      default: regSel = r_ccr;
    endcase
  endfunction

  // The only place din_io is ever driven; the enable is tied to the write
  // strobe so the bus is released whenever nrd_out could be low.
  assign din_io = w_busOe ? w_busData : 8'bz;

  assign a1_out             = w_addr[1];
  assign a0_out             = w_addr[0];
  assign host.fail_code_out = r_failCode;
  assign w_timerInc         = r_timer + 16'd1;

  // Next-state and Moore output decode. Every output is derived from
  // registered state only, so the bus strobes cannot glitch on host inputs.
  // WR walks r_step 0..7: even steps strobe nwr_out for address r_step[2:1],
  // odd steps are the idle gap with the bus released.
  always_comb begin
    w_stateNext        = r_state;
    w_stepNext         = r_step;
    w_cntNext          = r_cnt;
    w_timerNext        = r_timer;
    w_failCodeNext     = r_failCode;
    w_latch            = 1'b0;
    w_addr             = 2'b00;
    w_busOe            = 1'b0;
    w_busData          = 8'h00;
    ncs_out            = 1'b1;
    nrd_out            = 1'b1;
    nwr_out            = 1'b1;
    start_out          = 1'b0;
    host.busy_out      = 1'b1;
    host.done_out      = 1'b0;
    host.fail_out      = 1'b0;
`ifdef READBACK_EN
    w_mismatchNext     = r_mismatch;
`endif

    case (r_state)
      S_IDLE: begin
        host.busy_out = 1'b0;
        if (host.req_in) begin
          w_latch        = 1'b1;
          w_failCodeNext = 2'b00;
          w_stateNext    = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((r_llr <= r_plr) && (r_plr <= r_ulr) && (r_ccr != 8'd0)) begin
          w_stepNext  = 3'd0;
          w_stateNext = S_WR;
        end else begin
          w_failCodeNext = 2'b01;
          w_stateNext    = S_FAIL;
        end
      end

      S_WR: begin
        ncs_out   = 1'b0;
        w_addr    = r_step[2:1];
        w_busData = regSel(r_step[2:1]);
        if (!r_step[0]) begin
          nwr_out = 1'b0;
          w_busOe = 1'b1;
        end
        if (r_step == 3'd7) begin
          w_stepNext = 3'd0;
          w_cntNext  = '0;
`ifdef READBACK_EN
          w_mismatchNext = 1'b0;
          w_stateNext    = S_RD;
`else
          w_stateNext    = S_START;
`endif
        end else begin
          w_stepNext = r_step + 3'd1;
        end
      end

`ifdef READBACK_EN
      // Each readback holds nrd_out low for RD_WAIT cycles, samples on the
      // last low cycle, then spends one cycle with the strobe released. A
      // mismatch is only acted on in that released cycle so the read that
      // exposed it completes cleanly.
      S_RD: begin
        ncs_out = 1'b0;
        w_addr  = r_step[1:0];
        if (r_cnt < RD_LAST) begin
          nrd_out = 1'b0;
        end
        if ((r_cnt == RD_SAMPLE) && (din_io != regSel(r_step[1:0]))) begin
          w_mismatchNext = 1'b1;
        end
        if (r_cnt == RD_LAST) begin
          w_cntNext = '0;
          if (r_mismatch) begin
            w_failCodeNext = 2'b10;
            w_stateNext    = S_FAIL;
          end else if (r_step[1:0] == 2'd3) begin
            w_stepNext  = 3'd0;
            w_stateNext = S_START;
          end else begin
            w_stepNext = r_step + 3'd1;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
`endif

      S_START: begin
        ncs_out   = 1'b0;
        start_out = 1'b1;
        if (r_cnt == START_LAST) begin
          w_cntNext   = '0;
          w_timerNext = 16'd0;
          w_stateNext = S_RUN;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      // The timer holds the number of RUN cycles already completed, so the
      // timeout fires on the cycle that would make it reach TIMEOUT. End of
      // cycle is checked first so it wins over a simultaneous error.
      S_RUN: begin
        ncs_out     = 1'b0;
        w_timerNext = w_timerInc;
        if (ec_in) begin
          w_stateNext = S_DONE;
        end else if (err_in || (w_timerInc == TIMEOUT)) begin
          w_failCodeNext = 2'b11;
          w_stateNext    = S_FAIL;
        end
      end

      S_DONE: begin
        host.done_out = 1'b1;
        w_stateNext   = S_IDLE;
      end

      S_FAIL: begin
        host.fail_out = 1'b1;
        w_stateNext   = S_IDLE;
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset takes effect on the next edge and,
  // because every bus output is decoded from state, releases the bus then.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state    <= S_IDLE;
      r_plr      <= 8'd0;
      r_ulr      <= 8'd0;
      r_llr      <= 8'd0;
      r_ccr      <= 8'd0;
      r_step     <= 3'd0;
      r_cnt      <= '0;
      r_timer    <= 16'd0;
      r_failCode <= 2'b00;
`ifdef READBACK_EN
      r_mismatch <= 1'b0;
`endif
    end else begin
      r_state    <= w_stateNext;
      r_step     <= w_stepNext;
      r_cnt      <= w_cntNext;
      r_timer    <= w_timerNext;
      r_failCode <= w_failCodeNext;
`ifdef READBACK_EN
      r_mismatch <= w_mismatchNext;
`endif
      if (w_latch) begin
        r_plr <= host.plr_in;
        r_ulr <= host.ulr_in;
        r_llr <= host.llr_in;
        r_ccr <= host.ccr_in;
      end
    end
  end

endmodule
